// File: rtl/mem_rr_arb_pkg.sv
// Shared types and default widths for the two-requester round-robin memory arbiter.
package mem_arb_pkg;

   localparam int W_DEF      = 8;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic                  wrd;
      logic [ADDR_W_DEF-1:0] addr;
      logic [W_DEF-1:0]      wdata;
   } req_t;

endpackage

// File: rtl/mem_rr_arb_if.sv
// Requester and memory-side bundle for mem_rr_arb.
// With MEM_ARB_TIMEOUT_EN defined, r0_err/r1_err report an aborted transaction.
interface mem_rr_arb_if #(
   parameter int W      = 8,
   parameter int addr_w = 4
);
   // Handshake: a requester raises rN_valid with stable fields and holds them
   // until its one-cycle rN_ready pulse; the arbiter holds m_valid and m_* stable
   // until a one-cycle m_ready pulse, with m_rdata valid only while m_ready=1.
   logic              r0_valid;
   logic              r0_wrd;
   logic [addr_w-1:0] r0_addr;
   logic [W-1:0]      r0_wdata;
   logic              r0_ready;
   logic [W-1:0]      r0_rdata;

   logic              r1_valid;
   logic              r1_wrd;
   logic [addr_w-1:0] r1_addr;
   logic [W-1:0]      r1_wdata;
   logic              r1_ready;
   logic [W-1:0]      r1_rdata;

   logic              m_valid;
   logic              m_wrd;
   logic [addr_w-1:0] m_addr;
   logic [W-1:0]      m_wdata;
   logic              m_ready;
   logic [W-1:0]      m_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
   logic              r0_err;
   logic              r1_err;
`endif

   modport slave (
`ifdef MEM_ARB_TIMEOUT_EN
      output r0_err, r1_err,
`endif
      input  r0_valid, r0_wrd, r0_addr, r0_wdata,
      output r0_ready, r0_rdata,
      input  r1_valid, r1_wrd, r1_addr, r1_wdata,
      output r1_ready, r1_rdata,
      output m_valid, m_wrd, m_addr, m_wdata,
      input  m_ready, m_rdata
   );

   modport master (
`ifdef MEM_ARB_TIMEOUT_EN
      input  r0_err, r1_err,
`endif
      output r0_valid, r0_wrd, r0_addr, r0_wdata,
      input  r0_ready, r0_rdata,
      output r1_valid, r1_wrd, r1_addr, r1_wdata,
      input  r1_ready, r1_rdata,
      input  m_valid, m_wrd, m_addr, m_wdata,
      output m_ready, m_rdata
   );

endinterface

// File: rtl/mem_rr_arb_rr_pick2.sv
// Two-way round-robin priority function: on a tie the requester not served last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_rr_arb.sv
// Serialises two requesters onto one single-port RAM with round-robin grants.
// Define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT cycles.
module mem_rr_arb
   import mem_arb_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int addr_w = ADDR_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   mem_rr_arb_if.slave bus,
   output state_t      dbg_state
);

   state_t            state, state_nx;
   logic              last;
   logic              sel;
   logic [1:0]        gnt;
   logic              grant_go, done, finish, expired;
   logic              m_valid_q, m_wrd_q;
   logic [addr_w-1:0] m_addr_q;
   logic [W-1:0]      m_wdata_q;
   logic              r0_ready_q, r1_ready_q;
   logic [W-1:0]      r0_rdata_q, r1_rdata_q;

   rr_pick2 u_pick (
      .req  ({bus.r1_valid, bus.r0_valid}),
      .last (last),
      .gnt  (gnt)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
   logic             r0_err_q, r1_err_q;

   // Abort on the TIMEOUT-th BUSY edge that still has no m_ready.
   assign expired = (state == BUSY) && !bus.m_ready && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt      <= '0;
         r0_err_q <= 1'b0;
         r1_err_q <= 1'b0;
      end else begin
         r0_err_q <= 1'b0;
         r1_err_q <= 1'b0;
         if (grant_go) begin
            cnt <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
         end
         if (expired) begin
            if (sel) r1_err_q <= 1'b1;
            else     r0_err_q <= 1'b1;
         end
      end
   end

   assign bus.r0_err = r0_err_q;
   assign bus.r1_err = r1_err_q;
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      grant_go = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt != 2'b00) begin
               grant_go = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (bus.m_ready) begin
               done     = 1'b1;
               state_nx = RESP;
            end else if (expired) begin
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign finish = done | expired;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last       <= 1'b1;
         sel        <= 1'b0;
         m_valid_q  <= 1'b0;
         m_wrd_q    <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         r0_ready_q <= 1'b0;
         r1_ready_q <= 1'b0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
      end else begin
         r0_ready_q <= 1'b0;
         r1_ready_q <= 1'b0;
         if (grant_go) begin
            sel       <= gnt[1];
            m_valid_q <= 1'b1;
            m_wrd_q   <= gnt[1] ? bus.r1_wrd   : bus.r0_wrd;
            m_addr_q  <= gnt[1] ? bus.r1_addr  : bus.r0_addr;
            m_wdata_q <= gnt[1] ? bus.r1_wdata : bus.r0_wdata;
         end
         if (finish) begin
            m_valid_q <= 1'b0;
            last      <= sel;
            if (sel) r1_ready_q <= 1'b1;
            else     r0_ready_q <= 1'b1;
            // Read data is captured only for a completed read, never on abort.
            if (done && !m_wrd_q) begin
               if (sel) r1_rdata_q <= bus.m_rdata;
               else     r0_rdata_q <= bus.m_rdata;
            end
         end
      end
   end

   assign bus.m_valid  = m_valid_q;
   assign bus.m_wrd    = m_wrd_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.r0_ready = r0_ready_q;
   assign bus.r1_ready = r1_ready_q;
   assign bus.r0_rdata = r0_rdata_q;
   assign bus.r1_rdata = r1_rdata_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Directed bench for mem_rr_arb: memory responder, requester drivers, scoreboard.
// With MEM_ARB_TIMEOUT_EN defined, the timeout abort path is exercised as well.
module tb_mem_rr_arb;
  import mem_arb_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;

  typedef struct packed {
    logic         err;
    logic         id;
    req_t         req;
    logic [W-1:0] rdata;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_rr_arb_if #(.W(W), .addr_w(AW)) bus ();
  state_t dbg_state;

  mem_rr_arb #(.W(W), .addr_w(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int grants   = 0;
  int pulses   = 0;
  int aborted  = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  ref_mem [16];
  logic [W-1:0]  last_rd [2];
  logic [W-1:0]  mem     [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {bus.r0_ready, bus.r0_rdata, bus.r1_ready, bus.r1_rdata,
            bus.m_valid, bus.m_wrd, bus.m_addr, bus.m_wdata};
  endfunction

  // Reference model: expected results are pushed in grant order.
  task automatic push_exp(input logic id, input logic wrd, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic err);
    exp_t e;
    e.err = err;
    e.id  = id;
    e.req = '{wrd: wrd, addr: a, wdata: d};
    if (!err) begin
      if (wrd) ref_mem[a] = d;
      else     last_rd[id] = ref_mem[a];
    end
    e.rdata = last_rd[id];
    exp_q.push_back(EW'(e));
  endtask

  // ---------------- memory responder ----------------
  logic bfm_ready = 1'b0;
  logic inj_ready = 1'b0;
  logic mem_en    = 1'b1;
  int   mem_delay = 0;

  assign bus.m_ready = bfm_ready | inj_ready;

  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bfm_ready) begin
        bfm_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_en && rst && bus.m_valid) begin
        if (wait_cnt >= mem_delay) begin
          bfm_ready = 1'b1;
          if (bus.m_wrd) begin
            mem[bus.m_addr] = bus.m_wdata;
            bus.m_rdata     = W'($urandom);
          end else begin
            bus.m_rdata = mem[bus.m_addr];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic mv_q  = 1'b0;
  logic any_q = 1'b0;
  req_t cap   = '0;
  exp_t mon_e;
  logic err_obs;

  always @(negedge clk) begin
    if (bus.m_valid && !mv_q) begin
      cap = '{wrd: bus.m_wrd, addr: bus.m_addr, wdata: bus.m_wdata};
      grants++;
    end else if (bus.m_valid) begin
      chk("m_hold", 32'({bus.m_wrd, bus.m_addr, bus.m_wdata}), 32'(cap));
    end
    if (bus.r0_ready || bus.r1_ready) begin
      pulses++;
`ifdef MEM_ARB_TIMEOUT_EN
      err_obs = bus.r1_ready ? bus.r1_err : bus.r0_err;
`else
      err_obs = 1'b0;
`endif
      chk("one_ready", 32'(bus.r0_ready & bus.r1_ready), 32'(0));
      chk("ready_width", 32'(any_q), 32'(0));
      chk("q_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_t'(exp_q.pop_front());
        chk("grant_id", 32'(bus.r1_ready), 32'(mon_e.id));
        chk("m_fields", 32'(cap), 32'(mon_e.req));
        chk("rdata", 32'(bus.r1_ready ? bus.r1_rdata : bus.r0_rdata), 32'(mon_e.rdata));
        chk("err", 32'(err_obs), 32'(mon_e.err));
      end
    end
    mv_q  = bus.m_valid;
    any_q = bus.r0_ready | bus.r1_ready;
  end

  // ---------------- requester drivers ----------------
  task automatic set_req(input logic id, input logic wrd, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    if (id) begin
      bus.r1_valid = 1'b1; bus.r1_wrd = wrd; bus.r1_addr = a; bus.r1_wdata = d;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_wrd = wrd; bus.r0_addr = a; bus.r0_wdata = d;
    end
  endtask

  task automatic wait_ready(input logic id, output int lat);
    logic rdy;
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 200) begin
      @(negedge clk);
      lat++;
      rdy = id ? bus.r1_ready : bus.r0_ready;
    end
    chk(id ? "ready_seen_r1" : "ready_seen_r0", 32'(rdy), 32'(1));
    if (id) bus.r1_valid = 1'b0;
    else    bus.r0_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", outs(), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic           t_wrd  [6];
  logic [AW-1:0]  t_addr [6];
  logic [W-1:0]   t_data [6];
  int             lat;
  int             n;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      mem[i]     = '0;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    bus.r0_valid = 1'b0; bus.r0_wrd = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_valid = 1'b0; bus.r1_wrd = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;

    // Reset held for two edges while r0 already requests a write of 0xA5 to addr 3.
    rst       = 1'b0;
    mem_delay = 2;
    push_exp(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0);
    set_req(1'b0, 1'b1, 4'd3, 8'hA5);
    repeat (2) @(negedge clk);
    chk("rst_outs_r0valid", outs(), 32'(0));
    chk("rst_state_r0valid", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);
    chk("mv_after_rst", 32'(bus.m_valid), 32'(1));
    chk("busy_after_rst", 32'(dbg_state), 32'(BUSY));
    wait_ready(1'b0, lat);
    chk("write_latency", 32'(lat), 32'(3));

    // Back-to-back read of addr 3 with an immediate memory answer.
    mem_delay = 0;
    push_exp(1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    set_req(1'b0, 1'b0, 4'd3, 8'h00);
    wait_ready(1'b0, lat);
    chk("turnaround", 32'(lat), 32'(3));
    chk("r0_rdata_hold", 32'(bus.r0_rdata), 32'(8'hA5));

    // Simultaneous requests straight after reset: r0 first, then r1.
    do_reset();
    mem_delay = 1;
    push_exp(1'b0, 1'b1, 4'd5, 8'h3C, 1'b0);
    push_exp(1'b1, 1'b1, 4'd6, 8'hC3, 1'b0);
    fork
      begin set_req(1'b0, 1'b1, 4'd5, 8'h3C); wait_ready(1'b0, lat); end
      begin int l1; set_req(1'b1, 1'b1, 4'd6, 8'hC3); wait_ready(1'b1, l1); end
    join

    // Six transactions with both sides always requesting: grants alternate.
    mem_delay = $urandom_range(0, 3);
    for (int i = 0; i < 6; i++) begin
      t_wrd[i]  = 1'($urandom_range(0, 1));
      t_addr[i] = AW'($urandom_range(5, 8));
      t_data[i] = W'($urandom);
      push_exp(1'(i % 2), t_wrd[i], t_addr[i], t_data[i], 1'b0);
    end
    fork
      begin
        int l0;
        for (int i = 0; i < 6; i += 2) begin
          set_req(1'b0, t_wrd[i], t_addr[i], t_data[i]);
          wait_ready(1'b0, l0);
        end
      end
      begin
        int l1;
        for (int i = 1; i < 6; i += 2) begin
          set_req(1'b1, t_wrd[i], t_addr[i], t_data[i]);
          wait_ready(1'b1, l1);
        end
      end
    join

    // Stray m_ready while idle must be ignored.
    repeat (2) @(negedge clk);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    chk("idle_mready_state", 32'(dbg_state), 32'(IDLE));
    chk("idle_mready_rdy", 32'({bus.r0_ready, bus.r1_ready}), 32'(0));
    @(negedge clk);
    chk("idle_mready_rdy2", 32'({bus.r0_ready, bus.r1_ready}), 32'(0));
    chk("idle_mready_rd0", 32'(bus.r0_rdata), 32'(last_rd[0]));
    chk("idle_mready_rd1", 32'(bus.r1_rdata), 32'(last_rd[1]));

    // Reset in the middle of a BUSY transaction abandons it.
    mem_en = 1'b0;
    set_req(1'b1, 1'b1, 4'd2, 8'h77);
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(dbg_state), 32'(BUSY));
    rst = 1'b0;
    bus.r1_valid = 1'b0;
    aborted++;
    @(negedge clk);
    chk("abort_mvalid", 32'(bus.m_valid), 32'(0));
    chk("abort_rdy", 32'({bus.r0_ready, bus.r1_ready}), 32'(0));
    @(negedge clk);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst    = 1'b1;
    mem_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_pulse", 32'({bus.r0_ready, bus.r1_ready}), 32'(0));
    chk("abort_idle", 32'(dbg_state), 32'(IDLE));

    // Recovery: addr 2 was never written, addr 3 still holds 0xA5.
    push_exp(1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    set_req(1'b0, 1'b0, 4'd3, 8'h00);
    wait_ready(1'b0, lat);
    push_exp(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
    set_req(1'b1, 1'b0, 4'd2, 8'h00);
    wait_ready(1'b1, lat);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after 16 BUSY cycles with ready and err together.
    mem_en = 1'b0;
    push_exp(1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
    set_req(1'b1, 1'b0, 4'd4, 8'h00);
    n = 0;
    @(negedge clk);
    while (bus.m_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", 32'(n), 32'(16));
    chk("timeout_ready", 32'(bus.r1_ready), 32'(1));
    chk("timeout_err", 32'(bus.r1_err), 32'(1));
    bus.r1_valid = 1'b0;
    mem_en = 1'b1;
    push_exp(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    set_req(1'b1, 1'b0, 4'd3, 8'h00);
    wait_ready(1'b1, lat);
`endif

    repeat (3) @(negedge clk);
    chk("grants_vs_pulses", 32'(grants - aborted), 32'(pulses));
    chk("q_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_rr_arb.md
Name: mem_rr_arb

Overview:
- Two-requester round-robin arbiter sharing one single-port RAM.
- Each requester sees a private valid/wrd/addr/wdata -> ready/rdata port.
- The block serialises requests onto the single memory-side port (m_*).
- Sits between the testbench/BFM or client logic and the RAM; the memory side matches the RAM's existing valid/ready signalling.

Parameters:
- W, 8, data width in bits.
- addr_w, 4, address width in bits.
- TIMEOUT, 16, cycles to wait for m_ready before abort; only used when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- r0_valid  in  1  requester 0 request.
- r0_wrd  in  1  requester 0 direction: 1 = write, 0 = read.
- r0_addr  in  addr_w  requester 0 address.
- r0_wdata  in  W  requester 0 write data.
- r0_ready  out  1  requester 0 completion pulse.
- r0_rdata  out  W  requester 0 read data.
- r1_valid, r1_wrd, r1_addr, r1_wdata, r1_ready, r1_rdata: same as r0_*, for requester 1.
- m_valid  out  1  memory request.
- m_wrd  out  1  memory direction.
- m_addr  out  addr_w  memory address.
- m_wdata  out  W  memory write data.
- m_ready  in  1  memory completion; one-cycle pulse.
- m_rdata  in  W  memory read data; valid while m_ready=1.

Behaviour:
- Reset (rst=0 at posedge):
  - All outputs 0.
  - FSM goes to IDLE.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons the transaction; m_valid is 0 on the next cycle.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any rN_valid=1, grant by round robin: the requester not served last wins a tie; a sole requester always wins.
  - Latch that requester's wrd/addr/wdata into the m_* registers and set m_valid=1; go to BUSY.
  - If no rN_valid=1, stay in IDLE with m_valid=0.
- BUSY:
  - m_valid and the m_* fields are held stable.
  - On a posedge with m_ready=1:
    - m_valid <= 0.
    - Granted rN_ready <= 1.
    - If the request was a read, rN_rdata <= m_rdata; for a write, rN_rdata is unchanged.
    - Update the last-grant pointer; go to RESP.
- RESP:
  - The granted rN_ready is high for exactly this one cycle, then cleared.
  - Go to IDLE.
- Requester rules:
  - Hold valid and fields stable until its ready pulse.
  - In the cycle after the pulse, drop valid or present a new request.
  - Requester inputs are ignored except when sampled in IDLE.
- Latency:
  - Request sampled at edge k -> m_valid high from k+1.
  - m_ready sampled at edge j -> rN_ready high during cycle j+1.
  - Minimum turnaround is 3 cycles per transaction.
- Ungranted requester: its rN_ready stays 0; its request stays pending and wins the next IDLE arbitration if the other requester was just served.
- Continuous requests from both sides: grants alternate 0,1,0,1…
- m_ready while not in BUSY: ignored.
- rN_rdata holds its last value between reads.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Extra outputs r0_err and r1_err, 1 bit each, reset 0.
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without m_ready: m_valid <= 0, the granted rN_ready and rN_err are pulsed together for one cycle (RESP), rN_rdata is unchanged, and the pointer updates.
  - rN_err is 0 on normal completion.
- When undefined: no err ports and no counter; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - W and addr_w defaults.
  - typedef enum state_t {IDLE, BUSY, RESP}.
  - typedef struct req_t {wrd, addr, wdata}.
- Sub-module rr_pick2:
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0], one-hot or zero.
  - Purely the priority function; the pointer register stays in the parent.

Test Plan:
- Reset with rst=0 for 2 cycles while r0_valid=1 -> all outputs 0, m_valid stays 0 until the cycle after rst=1.
- r0 writes 0xA5 to addr 3, memory returns m_ready after 2 cycles; then r0 reads addr 3 -> m_wrd=1/m_addr=3/m_wdata=0xA5 held through BUSY; r0_ready pulses once; the read returns r0_rdata=0xA5.
- r0 and r1 both valid in the same cycle after reset -> r0 served first, then r1; r1_ready pulses exactly one cycle; r0_ready stays 0 during r1's transaction.
- Both requesters hold valid for 6 transactions -> grant order 0,1,0,1,0,1; every m_valid assertion is followed by exactly one ready pulse.
- m_ready pulsed while IDLE -> no rN_ready, state unchanged; reset asserted during BUSY -> m_valid=0 next cycle, no ready pulse.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=16, memory never answers -> m_valid drops after 16 BUSY cycles, r1_ready=r1_err=1 for one cycle, next request proceeds normally with err=0.
